f_div_sqrt_ctl: RTL and testbench

Issue and writeback controller for the shared iterative FP divide/square-root unit in the dual-issue FPU. It arbitrates div/sqrt requests from pipe 0 and pipe 1 and drives the unit's e1-stage inputs for the winner. It tracks the single in-flight operation through flush, holds the result until the register-file write port accepts it, and flags a hung unit with a watchdog.

---
 rtl/f_div_sqrt_ctl_if.sv | 22 ++
 rtl/f_div_sqrt_ctl.sv | 173 +++++++++++++++++
 tb/tb_f_div_sqrt_ctl.sv | 397 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/f_div_sqrt_ctl_if.sv
// Writeback handshake between the div/sqrt controller
// and the register-file write port.
interface f_div_sqrt_ctl_if #(
  parameter int TAG_W = 5
);
  logic             valid;
  logic             ready;
  logic [TAG_W-1:0] tag;
  logic             pipe;
  logic [64:0]      data;
  logic [4:0]       exc;

  modport master (
    output valid, tag, pipe, data, exc,
    input  ready
  );

  modport slave (
    input  valid, tag, pipe, data, exc,
    output ready
  );
endinterface

// File: rtl/f_div_sqrt_ctl.sv
// Issue/writeback control for the shared iterative
// FP div/sqrt unit: arbitration, flush, result hold.
module f_div_sqrt_ctl #(
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i0_valid,
  input  logic             i0_fdiv,
  input  logic             i0_fsqrt,
  input  logic             i0_fp64,
  input  logic [2:0]       i0_rm,
  input  logic [64:0]      i0_rs1,
  input  logic [64:0]      i0_rs2,
  input  logic [TAG_W-1:0] i0_tag,
  input  logic             i1_valid,
  input  logic             i1_fdiv,
  input  logic             i1_fsqrt,
  input  logic             i1_fp64,
  input  logic [2:0]       i1_rm,
  input  logic [64:0]      i1_rs1,
  input  logic [64:0]      i1_rs2,
  input  logic [TAG_W-1:0] i1_tag,
  input  logic             flush_lower,
  output logic             i0_stall,
  output logic             i1_stall,
  output logic             dv_valid,
  output logic [64:0]      dv_rs1,
  output logic [64:0]      dv_rs2,
  output logic             dv_fdiv,
  output logic             dv_fsqrt,
  output logic             dv_fp64,
  output logic [2:0]       dv_rm,
  output logic             dv_flush,
  input  logic             dv_stall,
  input  logic             dv_finish,
  input  logic [64:0]      dv_data,
  input  logic [4:0]       dv_exc,
  f_div_sqrt_ctl_if.master wb,
  output logic             busy,
  output logic             timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE,
    DRAIN
  } state_t;

  localparam logic [8:0] TO9 = 9'(TIMEOUT);

  state_t           state;
  logic             v_q;
  logic [TAG_W-1:0] tag_q;
  logic             pipe_q;
  logic [64:0]      data_q;
  logic [4:0]       exc_q;
  logic [7:0]       cnt;
  logic [7:0]       cnt_nx;

  logic req0, req1, can_issue;
  logic grant0, grant1;

  assign req0 = i0_valid & (i0_fdiv | i0_fsqrt);
  assign req1 = i1_valid & (i1_fdiv | i1_fsqrt);
  assign can_issue = (state == IDLE) & ~dv_stall
                   & ~flush_lower;
  assign grant0 = req0 & can_issue;
  assign grant1 = req1 & ~req0 & can_issue;

  assign i0_stall = req0 & ~grant0;
  assign i1_stall = req1 & ~grant1;
  assign dv_valid = grant0 | grant1;
  assign dv_flush = flush_lower;

  assign cnt_nx = (cnt == 8'hff) ? cnt : cnt + 8'd1;

  // Mux the granted pipe's op onto the unit inputs
  always_comb begin
    dv_rs1   = '0;
    dv_rs2   = '0;
    dv_fdiv  = 1'b0;
    dv_fsqrt = 1'b0;
    dv_fp64  = 1'b0;
    dv_rm    = '0;
    unique case (1'b1)
      grant0: begin
        dv_rs1   = i0_rs1;
        dv_rs2   = i0_rs2;
        dv_fdiv  = i0_fdiv & ~i0_fsqrt;
        dv_fsqrt = i0_fsqrt;
        dv_fp64  = i0_fp64;
        dv_rm    = i0_rm;
      end
      grant1: begin
        dv_rs1   = i1_rs1;
        dv_rs2   = i1_rs2;
        dv_fdiv  = i1_fdiv & ~i1_fsqrt;
        dv_fsqrt = i1_fsqrt;
        dv_fp64  = i1_fp64;
        dv_rm    = i1_rm;
      end
      default: ;
    endcase
  end

  // Op tracking FSM, result hold and watchdog
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      v_q         <= 1'b0;
      tag_q       <= '0;
      pipe_q      <= 1'b0;
      data_q      <= '0;
      exc_q       <= '0;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant0 | grant1) begin
            state  <= BUSY;
            busy   <= 1'b1;
            tag_q  <= grant1 ? i1_tag : i0_tag;
            pipe_q <= grant1;
            cnt    <= '0;
          end
        end
        BUSY: begin
          cnt <= cnt_nx;
          if ({1'b0, cnt_nx} >= TO9)
            timeout_err <= 1'b1;
          if (flush_lower) begin
            state <= DRAIN;
          end else if (dv_finish) begin
            state  <= DONE;
            v_q    <= 1'b1;
            data_q <= dv_data;
            exc_q  <= dv_exc;
          end
        end
        DONE: begin
          if (flush_lower | wb.ready) begin
            state <= IDLE;
            busy  <= 1'b0;
            v_q   <= 1'b0;
          end
        end
        DRAIN: begin
          if (!dv_stall) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          v_q   <= 1'b0;
        end
      endcase
    end
  end

  assign wb.valid = v_q;
  assign wb.tag   = tag_q;
  assign wb.pipe  = pipe_q;
  assign wb.data  = data_q;
  assign wb.exc   = exc_q;

endmodule

// File: tb/tb_f_div_sqrt_ctl.sv
// Bench for f_div_sqrt_ctl: directed scenarios plus
// random traffic against a transaction-level model.
module tb_f_div_sqrt_ctl;
  localparam int TW = 5;
  localparam int TO = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i0_valid, i0_fdiv, i0_fsqrt, i0_fp64;
  logic i1_valid, i1_fdiv, i1_fsqrt, i1_fp64;
  logic [2:0] i0_rm, i1_rm;
  logic [64:0] i0_rs1, i0_rs2, i1_rs1, i1_rs2;
  logic [TW-1:0] i0_tag, i1_tag;
  logic flush_lower;
  logic i0_stall, i1_stall, dv_valid;
  logic [64:0] dv_rs1, dv_rs2;
  logic dv_fdiv, dv_fsqrt, dv_fp64;
  logic [2:0] dv_rm;
  logic dv_flush, dv_stall, dv_finish;
  logic [64:0] dv_data;
  logic [4:0] dv_exc;
  logic busy, timeout_err;

  f_div_sqrt_ctl_if #(.TAG_W(TW)) wb();

  f_div_sqrt_ctl #(.TAG_W(TW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i0_valid(i0_valid), .i0_fdiv(i0_fdiv),
    .i0_fsqrt(i0_fsqrt), .i0_fp64(i0_fp64),
    .i0_rm(i0_rm), .i0_rs1(i0_rs1),
    .i0_rs2(i0_rs2), .i0_tag(i0_tag),
    .i1_valid(i1_valid), .i1_fdiv(i1_fdiv),
    .i1_fsqrt(i1_fsqrt), .i1_fp64(i1_fp64),
    .i1_rm(i1_rm), .i1_rs1(i1_rs1),
    .i1_rs2(i1_rs2), .i1_tag(i1_tag),
    .flush_lower(flush_lower),
    .i0_stall(i0_stall), .i1_stall(i1_stall),
    .dv_valid(dv_valid), .dv_rs1(dv_rs1),
    .dv_rs2(dv_rs2), .dv_fdiv(dv_fdiv),
    .dv_fsqrt(dv_fsqrt), .dv_fp64(dv_fp64),
    .dv_rm(dv_rm), .dv_flush(dv_flush),
    .dv_stall(dv_stall), .dv_finish(dv_finish),
    .dv_data(dv_data), .dv_exc(dv_exc),
    .wb(wb),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string n, logic [127:0] a,
                     logic [127:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t",
               n, a, e, $time);
    end
  endtask

  // ---- reference model: one op owned at a time ----
  logic m_run, m_hold, m_drain, m_err, m_pipe;
  logic [TW-1:0] m_tag;
  logic [64:0] m_data;
  logic [4:0] m_exc;
  int m_cnt;

  function automatic bit m_idle();
    return !(m_run || m_hold || m_drain);
  endfunction
  function automatic bit q0();
    return i0_valid && (i0_fdiv || i0_fsqrt);
  endfunction
  function automatic bit q1();
    return i1_valid && (i1_fdiv || i1_fsqrt);
  endfunction
  // winning pipe this cycle, -1 for none
  function automatic int win();
    if (!m_idle() || dv_stall || flush_lower)
      return -1;
    if (q0()) return 0;
    if (q1()) return 1;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 0; m_hold <= 0; m_drain <= 0;
      m_err <= 0; m_pipe <= 0; m_tag <= '0;
      m_data <= '0; m_exc <= '0; m_cnt <= 0;
    end else if (m_idle()) begin
      if (win() >= 0) begin
        m_run  <= 1;
        m_pipe <= (win() == 1);
        m_tag  <= (win() == 1) ? i1_tag : i0_tag;
        m_cnt  <= 0;
      end
    end else if (m_run) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt + 1 >= TO) m_err <= 1;
      if (flush_lower) begin
        m_run <= 0; m_drain <= 1;
      end else if (dv_finish) begin
        m_run <= 0; m_hold <= 1;
        m_data <= dv_data; m_exc <= dv_exc;
      end
    end else if (m_hold) begin
      if (flush_lower || wb.ready) m_hold <= 0;
    end else if (!dv_stall) begin
      m_drain <= 0;
    end
  end

  // ---- every-cycle compare against the model ----
  always @(negedge clk) begin
    int w;
    w = win();
    chk("dv_valid", dv_valid, w >= 0);
    chk("i0_stall", i0_stall, q0() && w != 0);
    chk("i1_stall", i1_stall, q1() && w != 1);
    chk("dv_rs1", dv_rs1,
        w == 0 ? i0_rs1 : w == 1 ? i1_rs1 : 65'd0);
    chk("dv_rs2", dv_rs2,
        w == 0 ? i0_rs2 : w == 1 ? i1_rs2 : 65'd0);
    chk("dv_rm", dv_rm,
        w == 0 ? i0_rm : w == 1 ? i1_rm : 3'd0);
    chk("dv_fp64", dv_fp64,
        w == 0 ? i0_fp64 : w == 1 ? i1_fp64 : 1'b0);
    chk("dv_fsqrt", dv_fsqrt,
        w == 0 ? i0_fsqrt : w == 1 ? i1_fsqrt : 1'b0);
    chk("dv_fdiv", dv_fdiv,
        w == 0 ? (i0_fdiv && !i0_fsqrt) :
        w == 1 ? (i1_fdiv && !i1_fsqrt) : 1'b0);
    chk("dv_flush", dv_flush, flush_lower);
    chk("busy", busy, !m_idle());
    chk("wb_valid", wb.valid, m_hold);
    chk("timeout_err", timeout_err, m_err);
    if (m_hold) begin
      chk("wb_tag", wb.tag, m_tag);
      chk("wb_pipe", wb.pipe, m_pipe);
      chk("wb_data", wb.data, m_data);
      chk("wb_exc", wb.exc, m_exc);
    end
  end

  // ---- stimulus helpers ----
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    i0_valid = 0; i0_fdiv = 0; i0_fsqrt = 0;
    i0_fp64 = 0; i0_rm = 0; i0_rs1 = 0;
    i0_rs2 = 0; i0_tag = 0;
    i1_valid = 0; i1_fdiv = 0; i1_fsqrt = 0;
    i1_fp64 = 0; i1_rm = 0; i1_rs1 = 0;
    i1_rs2 = 0; i1_tag = 0;
    flush_lower = 0; dv_stall = 0;
    dv_finish = 0; dv_data = 0; dv_exc = 0;
    wb.ready = 0;
  endtask

  function automatic logic [64:0] r65();
    return {1'($urandom), $urandom, $urandom};
  endfunction

  task automatic rnd_ops();
    i0_valid = ($urandom % 3) == 0;
    i0_fdiv  = 1'($urandom);
    i0_fsqrt = 1'($urandom);
    i0_fp64  = 1'($urandom);
    i0_rm    = 3'($urandom);
    i0_rs1   = r65();
    i0_rs2   = r65();
    i0_tag   = TW'($urandom);
    i1_valid = ($urandom % 3) == 0;
    i1_fdiv  = 1'($urandom);
    i1_fsqrt = 1'($urandom);
    i1_fp64  = 1'($urandom);
    i1_rm    = 3'($urandom);
    i1_rs1   = r65();
    i1_rs2   = r65();
    i1_tag   = TW'($urandom);
  endtask

  initial begin
    quiet();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst wb_valid", wb.valid, 0);
    chk("rst wb_tag", wb.tag, 0);
    chk("rst wb_pipe", wb.pipe, 0);
    chk("rst wb_data", wb.data, 0);
    chk("rst wb_exc", wb.exc, 0);
    chk("rst timeout_err", timeout_err, 0);
    cyc();

    // single fdiv, pipe 0, tag 7, 20-cycle unit
    i0_valid = 1; i0_fdiv = 1; i0_tag = 7;
    i0_rs1 = 65'h1_0000_0000_cafe_0001;
    @(negedge clk);
    chk("t1 dv_valid", dv_valid, 1);
    chk("t1 dv_fdiv", dv_fdiv, 1);
    chk("t1 dv_rs1", dv_rs1, 65'h1_0000_0000_cafe_0001);
    chk("t1 i0_stall", i0_stall, 0);
    cyc();
    i0_valid = 0;
    @(negedge clk);
    chk("t1 busy", busy, 1);
    chk("t1 no reissue", dv_valid, 0);
    repeat (19) cyc();
    dv_finish = 1;
    dv_data = 65'h0_1234_5678_9abc_def0;
    dv_exc = 5'h13;
    wb.ready = 1;
    cyc();
    dv_finish = 0; dv_data = 0; dv_exc = 0;
    @(negedge clk);
    chk("t1 wb_valid", wb.valid, 1);
    chk("t1 wb_tag", wb.tag, 7);
    chk("t1 wb_pipe", wb.pipe, 0);
    chk("t1 wb_data", wb.data, 65'h0_1234_5678_9abc_def0);
    chk("t1 wb_exc", wb.exc, 5'h13);
    cyc();
    @(negedge clk);
    chk("t1 wb_valid off", wb.valid, 0);
    chk("t1 busy off", busy, 0);
    chk("t1 timeout set", timeout_err, 1);
    cyc();
    rst_n = 0;
    #1;
    chk("t1 rst clears err", timeout_err, 0);
    cyc();
    rst_n = 1;
    wb.ready = 0;
    cyc();

    // both pipes request together
    i0_valid = 1; i0_fdiv = 1; i0_tag = 1;
    i1_valid = 1; i1_fdiv = 1; i1_fsqrt = 1;
    i1_tag = 2;
    @(negedge clk);
    chk("t2 dv_valid", dv_valid, 1);
    chk("t2 i0_stall", i0_stall, 0);
    chk("t2 i1_stall", i1_stall, 1);
    cyc();
    i0_valid = 0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) dv_finish = 1;
      @(negedge clk);
      chk("t2 busy stall1", i1_stall, 1);
      chk("t2 busy no issue", dv_valid, 0);
      cyc();
    end
    dv_finish = 0;
    wb.ready = 1;
    @(negedge clk);
    chk("t2 wb_pipe0", wb.pipe, 0);
    chk("t2 wb_tag1", wb.tag, 1);
    chk("t2 W no issue", dv_valid, 0);
    cyc();
    @(negedge clk);
    chk("t2 W+1 wb_valid", wb.valid, 0);
    chk("t2 W+1 issue", dv_valid, 1);
    chk("t2 W+1 i1_stall", i1_stall, 0);
    chk("t2 sqrt wins", dv_fsqrt, 1);
    chk("t2 fdiv clr", dv_fdiv, 0);
    cyc();
    i1_valid = 0;
    dv_finish = 1;
    cyc();
    dv_finish = 0;
    @(negedge clk);
    chk("t2 wb_pipe1", wb.pipe, 1);
    chk("t2 wb_tag2", wb.tag, 2);
    cyc();
    wb.ready = 0;

    // IDLE with unit stalled
    dv_stall = 1;
    i0_valid = 1; i0_fdiv = 1; i0_tag = 3;
    @(negedge clk);
    chk("t3 stall i0", i0_stall, 1);
    chk("t3 stall dv", dv_valid, 0);
    cyc();
    dv_stall = 0;
    @(negedge clk);
    chk("t3 issue", dv_valid, 1);
    cyc();
    i0_valid = 0;

    // flush together with finish, then drain
    flush_lower = 1; dv_finish = 1; dv_stall = 1;
    cyc();
    flush_lower = 0; dv_finish = 0;
    i0_valid = 1; i0_fsqrt = 1; i0_fdiv = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4 no wb", wb.valid, 0);
      chk("t4 drain busy", busy, 1);
      chk("t4 drain stall", i0_stall, 1);
      chk("t4 drain no issue", dv_valid, 0);
      cyc();
    end
    dv_stall = 0;
    @(negedge clk);
    chk("t4 fall no issue", dv_valid, 0);
    cyc();
    @(negedge clk);
    chk("t4 issue after fall", dv_valid, 1);
    cyc();
    i0_valid = 0;
    dv_finish = 1;
    cyc();
    dv_finish = 0;

    // held result then flush beats wb_ready
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t5 held", wb.valid, 1);
      cyc();
    end
    flush_lower = 1; wb.ready = 1;
    cyc();
    flush_lower = 0; wb.ready = 0;
    @(negedge clk);
    chk("t5 dropped", wb.valid, 0);
    chk("t5 idle", busy, 0);
    cyc();

    // reset while a result is held
    i1_valid = 1; i1_fdiv = 1; i1_tag = 9;
    cyc();
    i1_valid = 0; dv_finish = 1;
    cyc();
    dv_finish = 0;
    @(negedge clk);
    chk("t6 held", wb.valid, 1);
    cyc();
    rst_n = 0;
    #1;
    chk("t6 rst wb_valid", wb.valid, 0);
    chk("t6 rst busy", busy, 0);
    cyc();
    rst_n = 1;
    cyc();

    // watchdog with a unit that never finishes
    i0_valid = 1; i0_fdiv = 1;
    cyc();
    i0_valid = 0;
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      chk("t7 err low", timeout_err, 0);
      cyc();
    end
    @(negedge clk);
    chk("t7 err rise", timeout_err, 1);
    repeat (5) cyc();
    @(negedge clk);
    chk("t7 err sticky", timeout_err, 1);
    chk("t7 still busy", busy, 1);
    cyc();
    rst_n = 0;
    #1;
    chk("t7 err cleared", timeout_err, 0);
    cyc();
    rst_n = 1;
    cyc();

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      rnd_ops();
      flush_lower = ($urandom % 20) == 0;
      dv_stall = ($urandom % 4) == 0;
      dv_finish = ($urandom % 6) == 0;
      dv_data = r65();
      dv_exc = 5'($urandom);
      wb.ready = 1'($urandom);
      rst_n = (c % 500) != 499;
      cyc();
    end
    quiet();
    rst_n = 1;
    repeat (3) cyc();

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end
endmodule
